// File: rtl/sbox_scheduler.sv
// sbox_scheduler: round-robin time-share of one merged S-box between two word requesters,
// issuing the four bytes of each word serially and collecting results by delayed lane tag.
module sbox_scheduler #(
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic        req0_inv,
  input  logic        req1_inv,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp0_data,
  output logic [31:0] resp1_data,
  input  logic        resp0_ready,
  input  logic        resp1_ready,
  output logic [7:0]  sbox_u,
  output logic        sbox_zf,
  output logic        sbox_issue,
  input  logic [7:0]  sbox_r,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;
  state_t      state_q;
  logic        ptr_q, port_q, inv_q;
  logic [1:0]  lane_q;
  logic [31:0] word_q, res_q;
  logic        grant1, accept, hs, cap_v;
  logic [1:0]  cap_l;
  // rst_n gates ready so nothing is accepted before the first edge after release
  assign grant1      = req1_valid & (~req0_valid | ptr_q);
  assign accept      = rst_n & (state_q == IDLE) & (req0_valid | req1_valid);
  assign req0_ready  = accept & ~grant1;
  assign req1_ready  = accept & grant1;
  assign sbox_issue  = state_q == ISSUE;
  assign sbox_u      = sbox_issue ? word_q[{lane_q, 3'b000} +: 8] : 8'h00;
  assign sbox_zf     = inv_q;
  assign resp0_valid = (state_q == RESP) & ~port_q;
  assign resp1_valid = (state_q == RESP) & port_q;
  assign resp0_data  = resp0_valid ? res_q : 32'h0;
  assign resp1_data  = resp1_valid ? res_q : 32'h0;
  assign hs          = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);
  assign busy        = state_q != IDLE;
  generate
    if (SBOX_LAT == 0) begin : g_nolat
      assign cap_v = sbox_issue;
      assign cap_l = lane_q;
    end else begin : g_lat
      logic [2:0] tag_q [SBOX_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SBOX_LAT; i++) tag_q[i] <= 3'b000;
        end else begin
          tag_q[0] <= {sbox_issue, lane_q};
          for (int i = 1; i < SBOX_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
      end
      assign cap_v = tag_q[SBOX_LAT-1][2];
      assign cap_l = tag_q[SBOX_LAT-1][1:0];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      port_q  <= 1'b0;
      inv_q   <= 1'b0;
      lane_q  <= 2'd0;
      word_q  <= 32'h0;
      res_q   <= 32'h0;
    end else begin
      if (cap_v) res_q[{cap_l, 3'b000} +: 8] <= sbox_r;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= ISSUE;
          port_q  <= grant1;
          ptr_q   <= ~grant1;
          word_q  <= grant1 ? req1_data : req0_data;
          inv_q   <= grant1 ? req1_inv : req0_inv;
          lane_q  <= 2'd0;
        end
        ISSUE: begin
          lane_q <= lane_q + 2'd1;
          if (lane_q == 2'd3) state_q <= (SBOX_LAT == 0) ? RESP : DRAIN;
        end
        DRAIN: if (cap_v && cap_l == 2'd3) state_q <= RESP;
        RESP: if (hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_scheduler.sv
// tb_sbox_scheduler: scoreboard bench for sbox_scheduler; instance 1 (SBOX_LAT=1) is the main
// target, instances 0 and 2 (SBOX_LAT=0 and 3) cover latency variants with the same requests.
module tb_sbox_scheduler;
  logic clk = 0, rst_n = 0, rstx_n = 0;
  logic r0v = 0, r1v = 0, r0i = 0, r1i = 0, p0r = 1, p1r = 1;
  logic [31:0] r0d = 0, r1d = 0;
  logic [2:0] rq0, rq1, rv0, rv1, szf, sis, bsy;
  logic [2:0][31:0] rd0, rd1;
  logic [2:0][7:0] su, sr;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];
  logic [32:0] exp_q [$];
  logic [32:0] got;
  int checks = 0, fails = 0, cyc = 0;
  wire [78:0] outs1 = {rq0[1], rq1[1], rv0[1], rv1[1], rd0[1], rd1[1], su[1], szf[1], sis[1], bsy[1]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 2) ? 3 : g;
    logic [7:0] s0;
    logic [2:0][7:0] sp;
    wire [3:0][7:0] ch = {sp, s0};
    // external S-box: combinational lookup followed by L register stages
    always_comb s0 = szf[g] ? fwd_t[su[g]] : inv_t[su[g]];
    always_ff @(posedge clk) sp <= {sp[1:0], s0};
    assign sr[g] = ch[L];
    sbox_scheduler #(.SBOX_LAT(L)) u_dut (
      .clk(clk), .rst_n(g == 1 ? rst_n : rstx_n),
      .req0_valid(r0v), .req1_valid(r1v), .req0_data(r0d), .req1_data(r1d),
      .req0_inv(r0i), .req1_inv(r1i), .req0_ready(rq0[g]), .req1_ready(rq1[g]),
      .resp0_valid(rv0[g]), .resp1_valid(rv1[g]), .resp0_data(rd0[g]), .resp1_data(rd1[g]),
      .resp0_ready(p0r), .resp1_ready(p1r),
      .sbox_u(su[g]), .sbox_zf(szf[g]), .sbox_issue(sis[g]), .sbox_r(sr[g]), .busy(bsy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic chk(input string n, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // scoreboard monitor: one pop per response handshake on the main instance
  always @(negedge clk)
    if (rst_n && ((rv0[1] && p0r) || (rv1[1] && p1r))) begin
      got = rv1[1] ? {1'b1, rd1[1]} : {1'b0, rd0[1]};
      chk("sb_single", {rv0[1], rv1[1]} == 2'b11, 0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got %h expected none", got);
      end else chk("sb_resp", got, exp_q.pop_front());
    end

  task automatic wait_acc(input bit port, input logic [31:0] e, input bit push);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(rq0[1] | rq1[1]) && n < 30);
    chk("accept_port", {rq0[1], rq1[1]}, port ? 2'b01 : 2'b10);
    if (push) exp_q.push_back({port, e});
    @(posedge clk); #1;
    r0v = 0;
    r1v = 0;
  endtask

  task automatic issue(input bit port, input logic [31:0] d, input logic inv, input logic [31:0] e, input bit push);
    @(posedge clk); #1;
    if (port) begin r1v = 1; r1d = d; r1i = inv; end
    else begin r0v = 1; r0d = d; r0i = inv; end
    wait_acc(port, e, push);
  endtask

  task automatic txn(input bit port, input logic [31:0] d, input logic inv, input logic [31:0] e);
    issue(port, d, inv, e, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("issue_lane", {sis[1], su[1], szf[1], bsy[1]}, {1'b1, d[8*k +: 8], inv, 1'b1});
    end
    @(negedge clk);
    chk("drain", {sis[1], su[1], szf[1], rv0[1], rv1[1], bsy[1]}, {1'b0, 8'h00, inv, 2'b00, 1'b1});
    @(negedge clk);
    chk("resp_cycle", {rv0[1], rv1[1], port ? rd0[1] : rd1[1]}, {~port, port, 32'h0});
    @(negedge clk);
    chk("idle_after", {bsy[1], rv0[1], rv1[1]}, 3'b000);
  endtask

  task automatic drain_q();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("drain_q", exp_q.size(), 0);
  endtask

  task automatic round_robin();
    int last = 0, cnt = 0;
    r0v = 1; r0d = 32'h53020100; r0i = 1;
    r1v = 1; r1d = 32'h7C266E85; r1i = 0;
    for (int n = 0; n < 40 && cnt < 4; n++) begin
      @(negedge clk);
      if (rq0[1] | rq1[1]) begin
        chk("rr_grant", {rq0[1], rq1[1]}, cnt[0] ? 2'b01 : 2'b10);
        exp_q.push_back(cnt[0] ? {1'b1, 32'h01234567} : {1'b0, 32'hED777C63});
        if (cnt > 0) chk("rr_spacing", cyc - last, 7);
        last = cyc;
        cnt++;
      end
    end
    chk("rr_count", cnt, 4);
    @(posedge clk); #1;
    r0v = 0;
    r1v = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(i), 8'(c)) == 8'h01) b = 8'(c);
      fwd_t[i] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 256; i++) inv_t[fwd_t[i]] = 8'(i);
    r0v = 1;
    r1v = 1;
    #3;
    chk("reset_outs", outs1, 0);
    chk("reset_all", {rq0, rq1, rv0, rv1, sis, bsy, szf}, 0);
    @(posedge clk); #1;
    rst_n = 1;
    r0v = 0;
    r1v = 0;
    txn(0, 32'h53020100, 1, 32'hED777C63);
    txn(1, 32'h637C77ED, 0, 32'h00010253);
    // same request into all three latency variants
    @(posedge clk); #1;
    rstx_n = 1;
    r0v = 1; r0d = 32'h53020100; r0i = 1;
    @(negedge clk);
    chk("lat_accept", {rq0, rq1}, 6'b111000);
    exp_q.push_back({1'b0, 32'hED777C63});
    @(posedge clk); #1;
    r0v = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("lat_valid", rv0, {k == 8, k == 6, k == 5});
      for (int g = 0; g < 3; g++) if (rv0[g]) chk("lat_data", rd0[g], 32'hED777C63);
    end
    @(posedge clk); #1;
    rstx_n = 0;
    // stalled response with req1 waiting
    p0r = 0;
    issue(0, 32'h01234567, 1, 32'h7C266E85, 1);
    r1v = 1; r1d = 32'h7C266E85; r1i = 0;
    for (int n = 0; n < 20 && !rv0[1]; n++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("stall", {rv0[1], rd0[1], rq1[1], bsy[1]}, {1'b1, 32'h7C266E85, 1'b0, 1'b1});
      @(negedge clk);
    end
    @(posedge clk); #1;
    p0r = 1;
    wait_acc(1, 32'h01234567, 1);
    drain_q();
    // reset mid-transaction, pointer left favouring req1
    issue(0, 32'h53020100, 1, 32'h0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    r0v = 1; r0d = 32'h01234567; r0i = 1;
    r1v = 1; r1d = 32'h637C77ED; r1i = 0;
    chk("pre_abort", {sis[1], bsy[1], szf[1]}, 3'b111);
    #1 rst_n = 0;
    #1 chk("abort_zero", outs1, 0);
    @(posedge clk); #1;
    rst_n = 1;
    wait_acc(0, 32'h7C266E85, 1);
    drain_q();
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    round_robin();
    drain_q();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
